// File: rtl/cc1200_gpio_bank.sv
// GPIO bank for the CC1200 radio channels: synchronised, glitch-filtered pad
// inputs with edge-capture status, per-channel interrupts and a small register file.

module cc1200_gpio_pin #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 1
) (
    input  logic sysclk,
    input  logic rst,
    input  logic pad,
    output logic f,
    output logic upd
);
    logic [SYNC_STAGES-1:0] sync;
    logic [7:0]             cnt;
    logic                   s;

    assign s   = sync[SYNC_STAGES-1];
    // upd marks the edge on which f takes the new value, so it doubles as the edge strobe
    assign upd = (s != f) && (cnt == 8'(FILT_LEN - 1));

    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            f    <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pad};
            if (s == f) begin
                cnt <= '0;
            end else if (upd) begin
                f   <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

module cc1200_gpio_bank #(
    parameter int NCH         = 4,
    parameter int NPIN        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 1
) (
    input  logic                sysclk,
    input  logic                rst,
    input  logic                reg_wr,
    input  logic                reg_rd,
    input  logic [2:0]          reg_addr,
    input  logic [31:0]         reg_wdata,
    output logic [31:0]         reg_rdata,
    output logic                reg_rvalid,
    input  logic [NCH*NPIN-1:0] gpio_in,
    output logic [NCH*NPIN-1:0] gpio_out,
    output logic [NCH*NPIN-1:0] gpio_oen,
    output logic [NCH-1:0]      irq
);
    localparam int W = NCH * NPIN;

    logic [W-1:0]   out_r, oen_r, rise_en, fall_en, status, irq_en;
    logic [W-1:0]   f_vec, upd_vec, set_v, w1c, wd;
    logic [NCH-1:0] irq_nxt;
    logic [31:0]    rd_mux;

    assign gpio_out = out_r;
    assign gpio_oen = oen_r;
    assign wd       = reg_wdata[W-1:0];

    generate
        if (W < 32) begin : g_unused
            logic unused_wdata;
            assign unused_wdata = ^reg_wdata[31:W];
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_pin
            cc1200_gpio_pin #(
                .SYNC_STAGES(SYNC_STAGES),
                .FILT_LEN   (FILT_LEN)
            ) u_pin (
                .sysclk(sysclk),
                .rst   (rst),
                .pad   (gpio_in[gi]),
                .f     (f_vec[gi]),
                .upd   (upd_vec[gi])
            );
        end
        for (gi = 0; gi < NCH; gi++) begin : g_irq
            assign irq_nxt[gi] = |(status[gi*NPIN +: NPIN] & irq_en[gi*NPIN +: NPIN]);
        end
    endgenerate

    // f still holds the old level on the update edge: 0 means rising, 1 means falling
    assign set_v = upd_vec & ((~f_vec & rise_en) | (f_vec & fall_en));
    assign w1c   = (reg_wr && reg_addr == 3'd5) ? wd : '0;

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            3'd0:    rd_mux[W-1:0] = out_r;
            3'd1:    rd_mux[W-1:0] = oen_r;
            3'd2:    rd_mux[W-1:0] = f_vec;
            3'd3:    rd_mux[W-1:0] = rise_en;
            3'd4:    rd_mux[W-1:0] = fall_en;
            3'd5:    rd_mux[W-1:0] = status;
            3'd6:    rd_mux[W-1:0] = irq_en;
            default: rd_mux = {16'd0, 8'(FILT_LEN), 4'(NCH), 4'(NPIN)};
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            out_r      <= '0;
            oen_r      <= '0;
            rise_en    <= '0;
            fall_en    <= '0;
            status     <= '0;
            irq_en     <= '0;
            irq        <= '0;
            reg_rdata  <= '0;
            reg_rvalid <= 1'b0;
        end else begin
            if (reg_wr) begin
                case (reg_addr)
                    3'd0:    out_r   <= wd;
                    3'd1:    oen_r   <= wd;
                    3'd3:    rise_en <= wd;
                    3'd4:    fall_en <= wd;
                    3'd6:    irq_en  <= wd;
                    default: ;
                endcase
            end
            // set term is OR'd last so a new edge beats a same-cycle clear
            status     <= (status & ~w1c) | set_v;
            irq        <= irq_nxt;
            reg_rvalid <= reg_rd;
            reg_rdata  <= reg_rd ? rd_mux : '0;
        end
    end
endmodule
